multiplexador_varredura: RTL and testbench
==========================================

# multiplexador_varredura

Parametrised, registered N-channel data selector with manual, automatic-scan, priority and hold modes. It feeds the display and LED datapath, and it reports which channel currently drives the output. Enabled channels are chosen by a per-channel mask. All outputs are registered: one cycle of latency from inputs to `saida`.

## Interface
Parameters:
- `N_CANAIS`, 8: number of input channels; at least 2.
- `LARGURA`, 4: bits per channel.
- `DWELL`, 4: cycles each channel is held in scan mode; at least 1.
- `SEL_W` (localparam): `$clog2(N_CANAIS)`.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low. All state clears on assertion; release is synchronous to `clk`.
- `entradas`, input, `N_CANAIS*LARGURA`: packed channels; channel i occupies bits `[i*LARGURA +: LARGURA]`.
- `sel`, input, `SEL_W`: channel index used in manual mode.
- `modo`, input, 2: 00 manual, 01 scan, 10 priority, 11 hold.
- `habilita`, input, `N_CANAIS`: per-channel enable mask.
- `saida`, output, `LARGURA`: selected channel data, registered.
- `origem`, output, `SEL_W`: index of the channel driving `saida`, registered.
- `valida`, output, 1: `saida` comes from an enabled channel.
- `troca`, output, 1: one-cycle pulse; `origem` changed on this edge.

## Operation
- Each edge computes `nxt` (next origin) and `v` (next valid) from `modo`. It then registers:
  - `origem<=nxt`
  - `saida<=v ? entradas[nxt] : 0`
  - `valida<=v`
  - `troca<=(nxt!=origem)`
- Manual (00): `nxt=sel`, `v=habilita[sel]`. An out-of-range `sel` (when `N_CANAIS` is not a power of 2) gives `nxt=origem`, `v=0`.
- Scan (01):
  - A dwell counter `cnt` (width `$clog2(DWELL)`, minimum 1) runs.
  - If `cnt==DWELL-1`: `cnt<=0` and `nxt` = first enabled index strictly after `origem`, searched circularly (N_CANAIS-1 wraps to 0, and `origem` itself is last in the search).
  - Otherwise: `cnt<=cnt+1` and `nxt=origem`.
  - `v=habilita[nxt]`.
  - If no channel is enabled, `nxt=origem` and `v=0`.
  - Between steps, `saida` keeps tracking live data of `origem`.
- Priority (10):
  - `nxt` = lowest index i with `habilita[i]` and `entradas` channel i nonzero; `v=1`.
  - If no such channel exists: `nxt=origem`, `v=0`.
- Hold (11): `saida`, `origem` and `valida` keep their values; `troca<=0`.
- The dwell counter:
  - Clears to 0 on every edge where `modo!=01`, including hold.
  - Therefore entering scan always gives a full `DWELL` cycles on the current `origem` before the first step.
- `habilita` changes take effect on the next edge with no other latency. In scan, a channel disabled while selected gives `valida=0` until the next step; it is not skipped early.

## Timing
- Reset values: `saida=0`, `origem=0`, `valida=0`, `troca=0`, `cnt=0`.
- Reset asserted mid-scan clears everything immediately, with no wait for `clk`. The first edge after release evaluates normally from origin 0.
- Latency:
  - Input to `saida`: 1 cycle in all non-hold modes.
  - `troca` is aligned with the `origem` update on the same edge.
- Scan period: `origem` steps every `DWELL` edges. With `DWELL=1` it steps on every edge.
- Simultaneous events:
  - Mode change and step on the same edge: the new mode decides; the counter follows the clear rule.
  - `sel` equal to `origem` in manual mode: `troca=0`.

## Test plan
- Reset: `rst_n=0` with any inputs -> all outputs 0. Release, modo=00, sel=5, habilita=8'hFF, channel 5=4'hA -> next edge `saida=A`, `origem=5`, `valida=1`, `troca=1`. Following edge `troca=0`.
- Scan wrap: DWELL=4, habilita=8'b1000_0101, start origem=0 -> `origem` sequence 0,2,7,0, each held 4 cycles. `troca` pulses on each change, including 7->0.
- Scan, empty mask: habilita=0 in modo=01 -> `origem` frozen, `valida=0`, `saida=0`, `troca=0`. Setting habilita=8'h10 -> step to 4 at the next dwell boundary.
- Priority: habilita=8'hFF, channels 1 and 6 nonzero -> `origem=1`, `valida=1`. Clear channel 1 -> next edge `origem=6`, `troca=1`. All channels zero -> `valida=0`, `saida=0`, `origem=6`.
- Hold and async reset: in scan at cnt=2, switch to modo=11 for 10 cycles -> outputs frozen. Return to 01 -> first step after exactly 4 edges. Pulse `rst_n` low between edges -> outputs clear before the next edge.
- Manual with disabled channel: modo=00, sel=3, habilita[3]=0, channel 3=4'hF -> `saida=0`, `valida=0`, `origem=3`.

Source files
------------

// File: rtl/multiplexador_varredura.sv
// rtl/multiplexador_varredura.sv - registered N-channel selector with manual, scan, priority and hold modes
module multiplexador_varredura #(
    parameter int N_CANAIS = 8,
    parameter int LARGURA  = 4,
    parameter int DWELL    = 4,
    localparam int SEL_W   = $clog2(N_CANAIS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CANAIS*LARGURA-1:0] entradas,
    input  logic [SEL_W-1:0]            sel,
    input  logic [1:0]                  modo,
    input  logic [N_CANAIS-1:0]         habilita,
    output logic [LARGURA-1:0]          saida,
    output logic [SEL_W-1:0]            origem,
    output logic                        valida,
    output logic                        troca
);

    // A dwell of one cycle still needs a one-bit counter that is always at its terminal value
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        VARRE  = 2'b01,
        PRIOR  = 2'b10,
        PAUSA  = 2'b11
    } modo_t;

    logic [LARGURA-1:0] canal [N_CANAIS];
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SEL_W-1:0]   nxt;
    logic               v;
    logic [SEL_W-1:0]   prox_varre;
    logic [SEL_W-1:0]   idx;
    logic               achou_varre;
    logic [SEL_W-1:0]   prox_prio;
    logic               achou_prio;

    for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
        assign canal[g] = entradas[g*LARGURA +: LARGURA];
    end

    // Circular search for the first enabled channel after origem; origem itself is tried last
    always_comb begin
        prox_varre  = origem;
        achou_varre = 1'b0;
        idx         = origem;
        for (int k = 1; k <= N_CANAIS; k++) begin
            idx = SEL_W'((int'(origem) + k) % N_CANAIS);
            if (!achou_varre && habilita[idx]) begin
                prox_varre  = idx;
                achou_varre = 1'b1;
            end
        end
    end

    // Lowest enabled channel carrying nonzero data; descending loop so the lowest index wins
    always_comb begin
        prox_prio  = origem;
        achou_prio = 1'b0;
        for (int i = N_CANAIS - 1; i >= 0; i--) begin
            if (habilita[i] && (canal[i] != '0)) begin
                prox_prio  = SEL_W'(i);
                achou_prio = 1'b1;
            end
        end
    end

    // Next origin, validity and dwell count; the counter clears in every mode other than scan
    always_comb begin
        nxt     = origem;
        v       = 1'b0;
        cnt_nxt = '0;
        case (modo_t'(modo))
            MANUAL: begin
                if (int'(sel) < N_CANAIS) begin
                    nxt = sel;
                    v   = habilita[sel];
                end
            end
            VARRE: begin
                if (cnt == CNT_W'(DWELL - 1)) begin
                    cnt_nxt = '0;
                    if (achou_varre) begin
                        nxt = prox_varre;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
                v = habilita[nxt];
            end
            PRIOR: begin
                if (achou_prio) begin
                    nxt = prox_prio;
                    v   = 1'b1;
                end
            end
            default: begin
                nxt = origem;
                v   = 1'b0;
            end
        endcase
    end

    // Output registers; hold freezes data, origin and valid but still drops the change pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida  <= '0;
            origem <= '0;
            valida <= 1'b0;
            troca  <= 1'b0;
            cnt    <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (modo_t'(modo) != PAUSA) begin
                origem <= nxt;
                saida  <= v ? canal[nxt] : '0;
                valida <= v;
                troca  <= (nxt != origem);
            end else begin
                troca <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiplexador_varredura.sv
// tb/tb_multiplexador_varredura.sv - self-checking bench for multiplexador_varredura
module tb_multiplexador_varredura;

    localparam int N  = 8;
    localparam int LW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   entradas;
    logic [2:0]    sel;
    logic [1:0]    modo;
    logic [7:0]    habilita;
    logic [3:0]    saida;
    logic [2:0]    origem;
    logic          valida;
    logic          troca;

    int checks = 0;
    int errors = 0;

    int m_org, m_cnt, m_saida, m_val, m_troca;

    typedef struct {
        logic [1:0]  modo;
        logic [2:0]  sel;
        logic [7:0]  hab;
        logic [31:0] ent;
        logic [3:0]  e_saida;
        logic [2:0]  e_org;
        logic        e_val;
        logic        e_troca;
    } vec_t;

    vec_t tabela [10];

    multiplexador_varredura #(.N_CANAIS(N), .LARGURA(LW), .DWELL(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .entradas (entradas),
        .sel      (sel),
        .modo     (modo),
        .habilita (habilita),
        .saida    (saida),
        .origem   (origem),
        .valida   (valida),
        .troca    (troca)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nome, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_org = 0; m_cnt = 0; m_saida = 0; m_val = 0; m_troca = 0;
    endtask

    // Reference: advance one edge using the current inputs
    task automatic model_step();
        int ch [8];
        int nxt;
        int v;
        for (int i = 0; i < N; i++) ch[i] = int'((entradas >> (LW * i)) & 32'hF);
        if (modo == 2'd3) begin
            m_cnt = 0;
            m_troca = 0;
            return;
        end
        nxt = m_org;
        v = 0;
        if (modo == 2'd0) begin
            nxt = int'(sel);
            v = int'((habilita >> sel) & 8'd1);
        end else if (modo == 2'd1) begin
            if (m_cnt == DW - 1) begin
                m_cnt = 0;
                for (int k = 1; k <= N; k++) begin
                    if (((habilita >> ((m_org + k) % N)) & 8'd1) != 0) begin
                        nxt = (m_org + k) % N;
                        break;
                    end
                end
            end else begin
                m_cnt++;
            end
            v = int'((habilita >> nxt) & 8'd1);
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((((habilita >> i) & 8'd1) != 0) && ch[i] != 0) begin
                    nxt = i;
                    v = 1;
                    break;
                end
            end
        end
        if (modo != 2'd1) m_cnt = 0;
        m_troca = (nxt != m_org) ? 1 : 0;
        m_org = nxt;
        m_val = v;
        m_saida = (v != 0) ? ch[nxt] : 0;
    endtask

    task automatic tick_model(input string nome);
        model_step();
        @(posedge clk);
        #1;
        chk({nome, ".saida"}, int'(saida), m_saida);
        chk({nome, ".origem"}, int'(origem), m_org);
        chk({nome, ".valida"}, int'(valida), m_val);
        chk({nome, ".troca"}, int'(troca), m_troca);
    endtask

    initial begin
        int seq [4];
        int n;
        bit achou;

        tabela[0] = '{2'd0, 3'd5, 8'hFF, 32'h00A0_0000, 4'hA, 3'd5, 1'b1, 1'b1};
        tabela[1] = '{2'd0, 3'd5, 8'hFF, 32'h00A0_0000, 4'hA, 3'd5, 1'b1, 1'b0};
        tabela[2] = '{2'd0, 3'd3, 8'hF7, 32'h0000_F000, 4'h0, 3'd3, 1'b0, 1'b1};
        tabela[3] = '{2'd2, 3'd0, 8'hFF, 32'h0600_0010, 4'h1, 3'd1, 1'b1, 1'b1};
        tabela[4] = '{2'd2, 3'd0, 8'hFF, 32'h0600_0000, 4'h6, 3'd6, 1'b1, 1'b1};
        tabela[5] = '{2'd2, 3'd0, 8'hFF, 32'h0000_0000, 4'h0, 3'd6, 1'b0, 1'b0};
        tabela[6] = '{2'd2, 3'd0, 8'h7F, 32'h0600_0010, 4'h1, 3'd1, 1'b1, 1'b1};
        tabela[7] = '{2'd3, 3'd0, 8'hFF, 32'hFFFF_FFFF, 4'h1, 3'd1, 1'b1, 1'b0};
        tabela[8] = '{2'd0, 3'd1, 8'hFF, 32'h0000_0020, 4'h2, 3'd1, 1'b1, 1'b0};
        tabela[9] = '{2'd2, 3'd0, 8'h80, 32'h9000_0020, 4'h9, 3'd7, 1'b1, 1'b1};

        // Reset with arbitrary inputs
        rst_n = 1'b0;
        modo = 2'd1;
        sel = 3'($urandom);
        habilita = 8'($urandom);
        entradas = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.saida", int'(saida), 0);
        chk("rst.origem", int'(origem), 0);
        chk("rst.valida", int'(valida), 0);
        chk("rst.troca", int'(troca), 0);
        rst_n = 1'b1;
        model_reset();

        // Table vectors: manual, priority and hold basics
        for (int i = 0; i < 10; i++) begin
            modo = tabela[i].modo;
            sel = tabela[i].sel;
            habilita = tabela[i].hab;
            entradas = tabela[i].ent;
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.saida", i), int'(saida), int'(tabela[i].e_saida));
            chk($sformatf("vec%0d.origem", i), int'(origem), int'(tabela[i].e_org));
            chk($sformatf("vec%0d.valida", i), int'(valida), int'(tabela[i].e_val));
            chk($sformatf("vec%0d.troca", i), int'(troca), int'(tabela[i].e_troca));
        end

        // Scan wrap 0,2,7,0,2 with DWELL=4
        modo = 2'd0; sel = 3'd0; habilita = 8'hFF;
        tick_model("pre_scan");
        seq[0] = 2; seq[1] = 7; seq[2] = 0; seq[3] = 2;
        modo = 2'd1; habilita = 8'b1000_0101; entradas = 32'h8765_4321;
        for (int e = 1; e <= 16; e++) begin
            tick_model("scan");
            if (e % 4 == 0) begin
                chk("scan.step_origem", int'(origem), seq[e/4 - 1]);
                chk("scan.step_troca", int'(troca), 1);
            end
        end

        // Empty mask then a single enabled channel
        habilita = 8'h00;
        for (int e = 0; e < 6; e++) begin
            tick_model("empty");
            chk("empty.origem", int'(origem), 2);
            chk("empty.valida", int'(valida), 0);
            chk("empty.saida", int'(saida), 0);
            chk("empty.troca", int'(troca), 0);
        end
        habilita = 8'h10;
        achou = 1'b0;
        for (int e = 0; e < DW + 1 && !achou; e++) begin
            tick_model("mask10");
            if (origem == 3'd4) achou = 1'b1;
        end
        chk("mask10.reached4", int'(achou), 1);

        // Hold at cnt=2, then exactly DW edges to the first step
        modo = 2'd0; sel = 3'd1; habilita = 8'hFF;
        tick_model("pre_hold");
        modo = 2'd1;
        tick_model("scan_c1");
        tick_model("scan_c2");
        modo = 2'd3;
        for (int e = 0; e < 10; e++) begin
            entradas = $urandom;
            habilita = 8'($urandom);
            tick_model("hold");
            chk("hold.origem", int'(origem), 1);
            chk("hold.valida", int'(valida), 1);
            chk("hold.troca", int'(troca), 0);
        end
        modo = 2'd1; habilita = 8'hFF; entradas = 32'h1111_1111;
        n = 0;
        achou = 1'b0;
        for (int e = 0; e < 8 && !achou; e++) begin
            tick_model("resume");
            n++;
            if (origem != 3'd1) achou = 1'b1;
        end
        chk("resume.edges_to_step", n, DW);

        // Asynchronous reset between edges
        tick_model("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.saida", int'(saida), 0);
        chk("arst.origem", int'(origem), 0);
        chk("arst.valida", int'(valida), 0);
        chk("arst.troca", int'(troca), 0);
        model_reset();
        #2 rst_n = 1'b1;
        tick_model("post_rst");

        // Randomized traffic against the reference
        modo = 2'($urandom);
        for (int e = 0; e < 400; e++) begin
            if ($urandom_range(0, 7) == 0) modo = 2'($urandom);
            sel = 3'($urandom);
            habilita = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            entradas = $urandom & $urandom;
            tick_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
